// File: rtl/tdc_hit_collect_if.sv
// ---------------------------------------------------------------------------
// tdc_hit_collect_if
// Bus bundle between the edge-sum blocks / event consumer and tdc_hit_collect.
//   i_sum        : per-block edge-position sums, block k in bits [16k+15:16k]
//   i_hit_valid  : one-cycle strobe, i_sum carries a hit result
//   o_data       : FIFO head event word {coarse, fine[18:0]}
//   o_valid      : FIFO head word is valid
//   i_ready      : consumer accepts o_data when o_valid && i_ready
//   o_drop_cnt   : saturating count of events lost to a full FIFO
//   o_fifo_level : current FIFO occupancy
// Modports: master = producer/consumer side, slave = tdc_hit_collect.
// ---------------------------------------------------------------------------
interface tdc_hit_collect_if #(
   parameter int unsigned NUM_BLK    = 4,
   parameter int unsigned COARSE_W   = 24,
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned SUM_W  = 16 * NUM_BLK;
   localparam int unsigned DATA_W = COARSE_W + 19;
   localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

   logic [SUM_W-1:0]  i_sum;
   logic              i_hit_valid;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;
   logic [15:0]       o_drop_cnt;
   logic [LVL_W-1:0]  o_fifo_level;

   modport master (
      output i_sum, i_hit_valid, i_ready,
      input  o_data, o_valid, o_drop_cnt, o_fifo_level
   );

   modport slave (
      input  i_sum, i_hit_valid, i_ready,
      output o_data, o_valid, o_drop_cnt, o_fifo_level
   );
endinterface

// File: rtl/tdc_hit_collect.sv
// ---------------------------------------------------------------------------
// tdc_hit_collect
// Collects TDC hit results from NUM_BLK cascaded edge-sum blocks, stamps them
// with a latency-compensated coarse counter, adds the block sums into a
// 19-bit fine value and queues {coarse, fine} words in a first-word
// fall-through FIFO.  Hit-to-o_valid latency is three clock edges.
//
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   bus    : tdc_hit_collect_if.slave (i_sum, i_hit_valid, i_ready in;
//            o_data, o_valid, o_drop_cnt, o_fifo_level out)
//
// Parameters:
//   NUM_BLK    : number of edge-sum blocks (2, 4 or 8)
//   COARSE_W   : coarse counter width
//   LAT_COMP   : upstream latency subtracted from the coarse stamp
//   FIFO_DEPTH : output FIFO depth (power of 2, >= 2)
//
// Build option:
//   TDC_COLLECT_ZERO_SUPPRESS_EN : when defined, events whose fine value is
//   zero are dropped at stage 2 (not written, not counted as drops).
// ---------------------------------------------------------------------------
module tdc_hit_collect #(
   parameter int unsigned NUM_BLK    = 4,
   parameter int unsigned COARSE_W   = 24,
   parameter int unsigned LAT_COMP   = 9,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   tdc_hit_collect_if.slave bus
);

   localparam int unsigned BLK_W  = 16;
   localparam int unsigned SUM_W  = BLK_W * NUM_BLK;
   localparam int unsigned FINE_W = 19;
   localparam int unsigned DATA_W = COARSE_W + FINE_W;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned DROP_W = 16;

   // Free-running coarse counter
   logic [COARSE_W-1:0] coarse_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) coarse_q <= '0;
      else       coarse_q <= coarse_q + COARSE_W'(1);
   end

   // Stage 1: capture raw sums and the latency-compensated stamp
   logic                s1_valid_q;
   logic [SUM_W-1:0]    s1_sum_q;
   logic [COARSE_W-1:0] s1_coarse_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_coarse_q <= '0;
      end else begin
         s1_valid_q <= bus.i_hit_valid;
         if (bus.i_hit_valid) begin
            s1_sum_q    <= bus.i_sum;
            s1_coarse_q <= coarse_q - COARSE_W'(LAT_COMP);
         end
      end
   end

   // Fine value: 8 x 16-bit sums fit in 19 bits, so no truncation can occur
   logic [FINE_W-1:0] fine_c;

   always_comb begin
      fine_c = '0;
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
         fine_c = fine_c + FINE_W'(s1_sum_q[BLK_W*k +: BLK_W]);
      end
   end

   // Stage 2: event word ready for the FIFO
   logic              s2_valid_q;
   logic [DATA_W-1:0] s2_word_q;
   logic              s2_keep_c;

`ifdef TDC_COLLECT_ZERO_SUPPRESS_EN
   assign s2_keep_c = s1_valid_q && (fine_c != '0);
`else
   assign s2_keep_c = s1_valid_q;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         s2_word_q  <= '0;
      end else begin
         s2_valid_q <= s2_keep_c;
         if (s1_valid_q) s2_word_q <= {s1_coarse_q, fine_c};
      end
   end

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [PW-1:0]     level_q;
   logic [DROP_W-1:0] drop_q;

   logic              empty_c;
   logic              full_c;
   logic              pop_c;
   logic              push_c;
   logic              drop_c;
   logic [PW-1:0]     wr_ptr_nx_c;
   logic [PW-1:0]     rd_ptr_nx_c;
   logic [PW-1:0]     level_nx_c;
   logic [DATA_W-1:0] head_nx_c;

   always_comb begin
      empty_c = (wr_ptr_q == rd_ptr_q);
      full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW] != rd_ptr_q[AW]);
      pop_c   = !empty_c && bus.i_ready;
      // A full FIFO still accepts a write if the head leaves on the same edge
      push_c  = s2_valid_q && (!full_c || pop_c);
      drop_c  = s2_valid_q && full_c && !pop_c;

      wr_ptr_nx_c = wr_ptr_q + PW'(push_c);
      rd_ptr_nx_c = rd_ptr_q + PW'(pop_c);
      level_nx_c  = wr_ptr_nx_c - rd_ptr_nx_c;

      // New head is the word being written when it lands in the head slot
      if (push_c && (rd_ptr_nx_c == wr_ptr_q)) head_nx_c = s2_word_q;
      else                                      head_nx_c = mem[rd_ptr_nx_c[AW-1:0]];
   end

   // Storage array needs no reset; validity comes from the pointers
   always_ff @(posedge i_clk) begin
      if (push_c) mem[wr_ptr_q[AW-1:0]] <= s2_word_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         level_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_nx_c;
         rd_ptr_q <= rd_ptr_nx_c;
         valid_q  <= (level_nx_c != '0);
         level_q  <= level_nx_c;
         // o_data holds its last value while the FIFO is empty
         if (level_nx_c != '0) data_q <= head_nx_c;
         if (drop_c && (drop_q != {DROP_W{1'b1}})) drop_q <= drop_q + DROP_W'(1);
      end
   end

   assign bus.o_valid      = valid_q;
   assign bus.o_data       = data_q;
   assign bus.o_fifo_level = level_q;
   assign bus.o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_tdc_hit_collect.sv
// ---------------------------------------------------------------------------
// tb_tdc_hit_collect
// Self-checking bench for tdc_hit_collect: a queue-based event model is
// compared against the DUT every cycle, plus hand-computed literal cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdc_hit_collect;

   localparam int unsigned NUM_BLK    = 4;
   localparam int unsigned COARSE_W   = 24;
   localparam int unsigned LAT_COMP   = 9;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned DATA_W     = COARSE_W + 19;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   always #5 i_clk = ~i_clk;

   tdc_hit_collect_if #(
      .NUM_BLK(NUM_BLK), .COARSE_W(COARSE_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) bus ();

   tdc_hit_collect #(
      .NUM_BLK(NUM_BLK), .COARSE_W(COARSE_W),
      .LAT_COMP(LAT_COMP), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DATA_W-1:0] mq[$];       // words stored in the FIFO, head first
   logic [DATA_W-1:0] pend_w[$];   // accepted hits not yet written
   int unsigned       pend_e[$];   // edge index at which each lands
   int unsigned       e_idx;       // coarse value seen at the next edge
   int unsigned       m_drop;
   bit                m_pop, m_wr;
   logic [DATA_W-1:0] m_w;
   int unsigned       m_fine;
   bit                zs;

   initial begin
`ifdef TDC_COLLECT_ZERO_SUPPRESS_EN
      zs = 1'b1;
`else
      zs = 1'b0;
`endif
   end

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mq.delete(); pend_w.delete(); pend_e.delete();
         e_idx = 0; m_drop = 0;
      end else begin
         m_pop = (mq.size() != 0) && bus.i_ready;
         m_wr  = 1'b0;
         if (pend_e.size() != 0 && pend_e[0] == e_idx) begin
            m_wr = 1'b1;
            m_w  = pend_w.pop_front();
            void'(pend_e.pop_front());
         end
         if (bus.i_hit_valid) begin
            m_fine = 0;
            for (int k = 0; k < NUM_BLK; k++) m_fine += int'(bus.i_sum[16*k +: 16]);
            if (!(zs && m_fine == 0)) begin
               pend_w.push_back({COARSE_W'(e_idx - LAT_COMP), 19'(m_fine)});
               pend_e.push_back(e_idx + 2);
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_wr) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(m_w);
            else if (m_drop < 16'hFFFF) m_drop++;
         end
         e_idx++;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge i_clk) begin
      check("valid", 64'(bus.o_valid), 64'(mq.size() != 0));
      check("level", 64'(bus.o_fifo_level), 64'(mq.size()));
      check("drop",  64'(bus.o_drop_cnt), 64'(m_drop));
      if (mq.size() != 0 && bus.o_valid) check("data", 64'(bus.o_data), 64'(mq[0]));
   end

   // ---------------- stimulus helpers ----------------
   logic [DATA_W-1:0] d;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) tick();
      i_rst = 1'b0;
   endtask

   task automatic hit(input logic [63:0] sums);
      bus.i_sum       = sums;
      bus.i_hit_valid = 1'b1;
      tick();
      bus.i_hit_valid = 1'b0;
   endtask

   initial begin
      bus.i_sum       = '0;
      bus.i_hit_valid = 1'b0;
      bus.i_ready     = 1'b0;
      repeat (3) tick();
      check("rst_valid", 64'(bus.o_valid), 64'd0);
      check("rst_level", 64'(bus.o_fifo_level), 64'd0);
      check("rst_drop",  64'(bus.o_drop_cnt), 64'd0);
      check("rst_data",  64'(bus.o_data), 64'd0);
      i_rst = 1'b0;

      // Hit sampled at coarse 100 -> {91, 100} after three edges
      repeat (100) tick();
      hit({16'd40, 16'd30, 16'd20, 16'd10});
      tick();
      check("lat2_valid", 64'(bus.o_valid), 64'd0);
      tick();
      check("lat3_valid", 64'(bus.o_valid), 64'd1);
      check("c100_word", 64'(bus.o_data), 64'({24'd91, 19'd100}));

      // Coarse stamp wraps below zero
      do_reset();
      repeat (3) tick();
      hit({16'd0, 16'd0, 16'd0, 16'd1});
      repeat (2) tick();
      check("wrap_word", 64'(bus.o_data), 64'({24'hFFFFFA, 19'd1}));

      // Largest fine value
      do_reset();
      hit({4{16'hFFFF}});
      repeat (2) tick();
      d = bus.o_data;
      check("fine_max", 64'(d[18:0]), 64'h3FFFC);

      // Ten back-to-back hits into a stalled FIFO
      do_reset();
      for (int k = 0; k < 10; k++) begin
         bus.i_sum = {48'd0, 16'(k + 1)};
         bus.i_hit_valid = 1'b1;
         tick();
      end
      bus.i_hit_valid = 1'b0;
      repeat (3) tick();
      check("full_level", 64'(bus.o_fifo_level), 64'd8);
      check("full_drop",  64'(bus.o_drop_cnt), 64'd2);
      bus.i_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         d = bus.o_data;
         check("drain_order", 64'(d[18:0]), 64'(k + 1));
         tick();
      end
      bus.i_ready = 1'b0;
      check("drained_valid", 64'(bus.o_valid), 64'd0);

      // Async reset with five words stored and a nonzero drop count
      for (int k = 0; k < 5; k++) hit({48'd0, 16'(k + 7)});
      repeat (3) tick();
      check("five_level", 64'(bus.o_fifo_level), 64'd5);
      #2 i_rst = 1'b1;
      #1;
      check("arst_valid", 64'(bus.o_valid), 64'd0);
      check("arst_level", 64'(bus.o_fifo_level), 64'd0);
      check("arst_drop",  64'(bus.o_drop_cnt), 64'd0);
      tick();
      do_reset();

      // Full FIFO with a write and a pop on the same edge
      for (int k = 0; k < 8; k++) hit({48'd0, 16'(k + 1)});
      repeat (3) tick();
      check("fill_level", 64'(bus.o_fifo_level), 64'd8);
      hit({48'd0, 16'd99});
      tick();
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      check("wrpop_level", 64'(bus.o_fifo_level), 64'd8);
      check("wrpop_drop",  64'(bus.o_drop_cnt), 64'd0);
      d = bus.o_data;
      check("wrpop_head", 64'(d[18:0]), 64'd2);

      // Zero-valued event
      do_reset();
      hit(64'd0);
      repeat (3) tick();
      check("zero_level", 64'(bus.o_fifo_level), zs ? 64'd0 : 64'd1);

      // Randomized traffic with one asynchronous reset in the middle
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bus.i_hit_valid = ($urandom_range(0, 1) == 1);
         bus.i_sum       = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) bus.i_sum = '0;
         bus.i_ready     = ($urandom_range(0, 9) < 6);
         if (i == 1500) begin
            #3 i_rst = 1'b1;
            tick();
            i_rst = 1'b0;
         end else begin
            tick();
         end
      end
      bus.i_hit_valid = 1'b0;
      bus.i_ready     = 1'b1;
      repeat (20) tick();
      check("final_empty", 64'(bus.o_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdc_hit_collect.md
TDC_HIT_COLLECT -- requirements
Module: tdc_hit_collect

Interface
REQ-001 The block SHALL have parameter NUM_BLK, default 4, meaning the number of cascaded edge-sum blocks feeding it (legal values 2, 4, 8).
REQ-002 The block SHALL have parameter COARSE_W, default 24, meaning the coarse-counter width in bits.
REQ-003 The block SHALL have parameter LAT_COMP, default 9, meaning the upstream edge-sum latency in clocks, subtracted from the coarse stamp.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the output FIFO depth in words (power of 2, minimum 2).
REQ-005 i_clk  input  1  clock; reset i_rst, asynchronous, active-high; clock i_clk.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_sum  input  16*NUM_BLK  per-block edge-position sums; block k occupies bits [16k+15:16k].
REQ-008 i_hit_valid  input  1  high for one cycle when i_sum carries a hit result.
REQ-009 o_data  output  COARSE_W+19  event word {coarse, fine}; fine is the low 19 bits.
REQ-010 o_valid  output  1  FIFO head word is valid.
REQ-011 i_ready  input  1  consumer accepts o_data when o_valid and i_ready are both high.
REQ-012 o_drop_cnt  output  16  count of events lost to a full FIFO.
REQ-013 o_fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A free-running coarse counter SHALL increment by 1 on every clock and wrap modulo 2^COARSE_W.
REQ-015 Stage 1 SHALL register i_sum, i_hit_valid and (coarse counter - LAT_COMP) mod 2^COARSE_W on the edge E0 at which i_hit_valid is sampled high.
REQ-016 Stage 2 SHALL register fine = unsigned sum of all NUM_BLK block sums, zero-extended to 19 bits with no truncation, on E1.
REQ-017 The event word SHALL be written into the FIFO on E2, and o_valid SHALL be high after E2 when the FIFO was empty (first-word fall-through), giving a 3-edge latency.
REQ-018 Back-to-back i_hit_valid on consecutive cycles SHALL each produce one word, in order, with no bubbles.
REQ-019 A word SHALL be popped on every edge where o_valid and i_ready are both high, and o_data SHALL present the next word, or hold with o_valid low when empty.
REQ-020 When the FIFO is full and a write arrives with no pop in the same cycle, the new word SHALL be discarded and o_drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-021 When the FIFO is full and a write and a pop occur in the same cycle, both SHALL be accepted and the level SHALL remain FIFO_DEPTH.
REQ-022 When the FIFO is empty, i_ready SHALL have no effect, and a pop SHALL never underflow.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from an extra pointer bit.
REQ-024 o_fifo_level SHALL equal the number of stored words after each edge.

Reset
REQ-025 Assertion of i_rst SHALL immediately clear the coarse counter, all pipeline registers and valids, FIFO pointers, o_valid, o_data, o_fifo_level and o_drop_cnt to 0.
REQ-026 Events in flight during reset SHALL be lost, and the first edge after deassertion SHALL start the coarse counter from 0.

Configuration
REQ-027 With macro TDC_COLLECT_ZERO_SUPPRESS_EN defined, events with fine == 0 SHALL be discarded at stage 2, not written, and not counted in o_drop_cnt.
REQ-028 Without TDC_COLLECT_ZERO_SUPPRESS_EN, every i_hit_valid event, including fine == 0, SHALL be written.

Verification
REQ-029 Reset released, i_hit_valid at coarse=100 with sums {10,20,30,40} -> after 3 edges o_valid=1 and o_data={91, 19'd100}.
REQ-030 i_hit_valid at coarse=3 with LAT_COMP=9, COARSE_W=24 -> coarse field = 24'hFFFFFA (wrap).
REQ-031 All sums 16'hFFFF -> fine = 19'h3FFFC with no overflow.
REQ-032 i_ready=0 and 10 hits -> level=8, o_drop_cnt=2; then i_ready=1 drains 8 words in order.
REQ-033 FIFO full, then hit and pop on the same edge -> level stays 8, o_drop_cnt unchanged.
REQ-034 i_rst asserted with 5 words stored -> o_valid=0, level=0, o_drop_cnt=0 immediately; sums all 0 with the macro defined -> no word is written.
